// File: rtl/adc_spi_responder_if.sv
// SPI pin bundle between an ADC master (driver) and the responder.
// cs is active low; sclk idles low; dout_oe gates the pad driver.
interface adc_spi_responder_if;
  logic sclk;
  logic cs;
  logic din;
  logic dout;
  logic dout_oe;

  modport master (
    output sclk,
    output cs,
    output din,
    input  dout,
    input  dout_oe
  );

  modport slave (
    input  sclk,
    input  cs,
    input  din,
    output dout,
    output dout_oe
  );
endinterface

// File: rtl/adc_spi_responder.sv
// Emulates a 2-channel serial ADC on an SPI bus. sclk/cs/din are oversampled in the clk_i domain;
// no logic is clocked by sclk.
module adc_spi_responder #(
  parameter int unsigned DATA_W      = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  adc_spi_responder_if.slave spi,
  input  logic [DATA_W-1:0] ch0_data_i,
  input  logic [DATA_W-1:0] ch1_data_i,
  output logic [DATA_W-1:0] conv_value_o,
  output logic [2:0]        conv_cfg_o,
  output logic              conv_done_o,
  output logic              frame_err_o
);

  localparam int unsigned IdxW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StCfg,
    StNull,
    StMsbOut,
    StLsbOut,
    StTrail
  } state_e;

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, din_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, din_s;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.cs};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], spi.din};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // Conversion value selection
  logic              sgl_q, sgl_d, odd_q, odd_d;
  logic [DATA_W:0]   diff_01, diff_10;
  logic [DATA_W-1:0] conv_sel;

  assign diff_01 = {1'b0, ch0_data_i} - {1'b0, ch1_data_i};
  assign diff_10 = {1'b0, ch1_data_i} - {1'b0, ch0_data_i};

  // Differential results saturate at zero: a borrow out of the extra bit means negative.
  always_comb begin
    conv_sel = '0;
    unique case ({sgl_q, odd_q})
      2'b10:   conv_sel = ch0_data_i;
      2'b11:   conv_sel = ch1_data_i;
      2'b00:   conv_sel = diff_01[DATA_W] ? '0 : diff_01[DATA_W-1:0];
      default: conv_sel = diff_10[DATA_W] ? '0 : diff_10[DATA_W-1:0];
    endcase
  end

  // Frame FSM
  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [1:0]        cfg_cnt_q, cfg_cnt_d;
  logic              dout_q, dout_d, oe_q, oe_d;
  logic [DATA_W-1:0] conv_value_q, conv_value_d;
  logic [2:0]        conv_cfg_q, conv_cfg_d;
  logic              conv_done_q, conv_done_d, frame_err_q, frame_err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cfg_cnt_q    <= '0;
      sgl_q        <= 1'b0;
      odd_q        <= 1'b0;
      dout_q       <= 1'b0;
      oe_q         <= 1'b0;
      conv_value_q <= '0;
      conv_cfg_q   <= '0;
      conv_done_q  <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cfg_cnt_q    <= cfg_cnt_d;
      sgl_q        <= sgl_d;
      odd_q        <= odd_d;
      dout_q       <= dout_d;
      oe_q         <= oe_d;
      conv_value_q <= conv_value_d;
      conv_cfg_q   <= conv_cfg_d;
      conv_done_q  <= conv_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cfg_cnt_d    = cfg_cnt_q;
    sgl_d        = sgl_q;
    odd_d        = odd_q;
    dout_d       = dout_q;
    oe_d         = oe_q;
    conv_value_d = conv_value_q;
    conv_cfg_d   = conv_cfg_q;
    conv_done_d  = 1'b0;
    frame_err_d  = 1'b0;

    // cs rise overrides any sclk edge seen in the same cycle.
    if (cs_rise) begin
      state_d = StIdle;
      dout_d  = 1'b0;
      oe_d    = 1'b0;
      if (state_q == StCfg || state_q == StNull || state_q == StMsbOut) begin
        frame_err_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) state_d = StWaitStart;
        end
        StWaitStart: begin
          if (sclk_rise && din_s) begin
            state_d   = StCfg;
            cfg_cnt_d = '0;
          end
        end
        StCfg: begin
          if (sclk_rise) begin
            case (cfg_cnt_q)
              2'd0: begin
                sgl_d     = din_s;
                cfg_cnt_d = 2'd1;
              end
              2'd1: begin
                odd_d     = din_s;
                cfg_cnt_d = 2'd2;
              end
              default: begin
                conv_value_d = conv_sel;
                conv_cfg_d   = {sgl_q, odd_q, din_s};
                state_d      = StNull;
              end
            endcase
          end
        end
        StNull: begin
          if (sclk_fall) begin
            oe_d    = 1'b1;
            dout_d  = 1'b0;
            idx_d   = IdxW'(DATA_W - 1);
            state_d = StMsbOut;
          end
        end
        StMsbOut: begin
          if (sclk_fall) begin
            dout_d = conv_value_q[idx_q];
            if (idx_q == '0) begin
              conv_done_d = 1'b1;
              if (conv_cfg_q[0]) begin
                state_d = StTrail;
              end else begin
                state_d = StLsbOut;
                idx_d   = IdxW'(1);
              end
            end else begin
              idx_d = idx_q - IdxW'(1);
            end
          end
        end
        StLsbOut: begin
          if (sclk_fall) begin
            dout_d = conv_value_q[idx_q];
            if (idx_q == IdxW'(DATA_W - 1)) begin
              state_d = StTrail;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end
        end
        StTrail: begin
          if (sclk_fall) dout_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign spi.dout     = dout_q;
  assign spi.dout_oe  = oe_q;
  assign conv_value_o = conv_value_q;
  assign conv_cfg_o   = conv_cfg_q;
  assign conv_done_o  = conv_done_q;
  assign frame_err_o  = frame_err_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Bench for adc_spi_responder: directed frames plus randomized frames, checked against a
// bit-stream model built from the ADC framing rules.
module tb_adc_spi_responder;
  localparam int DW   = 10;
  localparam int SS   = 2;
  localparam int HALF = 6;

  logic          clk_i  = 1'b0;
  logic          rst_ni = 1'b0;
  logic [DW-1:0] ch0_data, ch1_data, conv_value;
  logic [2:0]    conv_cfg;
  logic          conv_done, frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  always #5 clk_i = ~clk_i;

  adc_spi_responder_if spi_if ();

  adc_spi_responder #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .spi          (spi_if.slave),
    .ch0_data_i   (ch0_data),
    .ch1_data_i   (ch1_data),
    .conv_value_o (conv_value),
    .conv_cfg_o   (conv_cfg),
    .conv_done_o  (conv_done),
    .frame_err_o  (frame_err)
  );

  always @(posedge clk_i) begin
    if (conv_done) done_cnt <= done_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_value(input logic sgl, input logic odd, input int c0, input int c1);
    int d;
    if (sgl) return odd ? c1 : c0;
    d = odd ? (c1 - c0) : (c0 - c1);
    return (d < 0) ? 0 : d;
  endfunction

  // One sclk period: set din, rise, fall, then sample dout late in the low phase.
  task automatic spi_clk(input logic b, output logic d, output logic oe);
    spi_if.din = b;
    repeat (HALF) @(negedge clk_i);
    spi_if.sclk = 1'b1;
    repeat (HALF) @(negedge clk_i);
    spi_if.sclk = 1'b0;
    repeat (HALF) @(negedge clk_i);
    d  = spi_if.dout;
    oe = spi_if.dout_oe;
  endtask

  // n_post = clocks after the MSBF clock before cs is raised (22 = full frame plus trailing zeros).
  task automatic run_frame(input string tag, input int n_lead, input logic sgl, input logic odd,
                           input logic msbf, input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                           input int n_post);
    logic [22:0] obs_s, exp_s, obs_oe, exp_oe;
    logic        d, oe;
    int          v, d0, e0, nb;
    bit          full;
    ch0_data = c0;
    ch1_data = c1;
    v = model_value(sgl, odd, int'(c0), int'(c1));
    for (int k = 0; k < 23; k++) begin
      exp_s[22-k] = 1'b0;
      if (k >= 1 && k <= 10) exp_s[22-k] = 1'((v >> (10 - k)) & 1);
      if (k >= 11 && k <= 19 && !msbf) exp_s[22-k] = 1'((v >> (k - 10)) & 1);
    end
    exp_oe = '1;
    obs_s  = '0;
    obs_oe = '0;
    d0 = done_cnt;
    e0 = err_cnt;
    full = (n_post >= 10);

    spi_if.cs = 1'b0;
    repeat (4) @(negedge clk_i);
    repeat (n_lead) spi_clk(1'b0, d, oe);
    spi_clk(1'b1, d, oe);
    spi_clk(sgl, d, oe);
    check({tag, "_oe_before_null"}, 32'(oe), 32'd0);
    spi_clk(odd, d, oe);
    spi_clk(msbf, d, oe);
    obs_s[22]  = d;
    obs_oe[22] = oe;
    for (int k = 1; k <= n_post; k++) begin
      spi_clk(1'b0, d, oe);
      obs_s[22-k]  = d;
      obs_oe[22-k] = oe;
    end
    nb = 1 + n_post;
    check({tag, "_stream"}, 32'(obs_s >> (23 - nb)), 32'(exp_s >> (23 - nb)));
    check({tag, "_oe_stream"}, 32'(obs_oe >> (23 - nb)), 32'(exp_oe >> (23 - nb)));

    spi_if.cs = 1'b1;
    repeat (SS + 2) @(negedge clk_i);
    check({tag, "_oe_after_cs"}, 32'(spi_if.dout_oe), 32'd0);
    check({tag, "_dout_after_cs"}, 32'(spi_if.dout), 32'd0);
    repeat (2) @(negedge clk_i);
    check({tag, "_conv_value"}, 32'(conv_value), 32'(v));
    check({tag, "_conv_cfg"}, 32'(conv_cfg), 32'({sgl, odd, msbf}));
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), full ? 32'd1 : 32'd0);
    check({tag, "_err_pulses"}, 32'(err_cnt - e0), full ? 32'd0 : 32'd1);
    repeat (4) @(negedge clk_i);
  endtask

  initial begin
    logic d, oe;
    int   e0;
    spi_if.sclk = 1'b0;
    spi_if.cs   = 1'b1;
    spi_if.din  = 1'b0;
    ch0_data    = '0;
    ch1_data    = '0;
    repeat (3) @(negedge clk_i);
    check("reset_dout", 32'(spi_if.dout), 32'd0);
    check("reset_oe", 32'(spi_if.dout_oe), 32'd0);
    check("reset_conv_value", 32'(conv_value), 32'd0);
    check("reset_conv_cfg", 32'(conv_cfg), 32'd0);
    check("reset_conv_done", 32'(conv_done), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);

    run_frame("t1", 0, 1'b1, 1'b0, 1'b1, 10'h2A5, 10'h000, 22);
    run_frame("t2", 0, 1'b1, 1'b1, 1'b0, 10'h0AA, 10'h301, 22);
    run_frame("t3_odd1", 0, 1'b0, 1'b1, 1'b1, 10'd100, 10'd300, 22);
    run_frame("t3_odd0", 0, 1'b0, 1'b0, 1'b1, 10'd100, 10'd300, 22);
    run_frame("t4", 3, 1'b1, 1'b0, 1'b1, 10'h2A5, 10'h000, 22);
    run_frame("t5_abort", 0, 1'b1, 1'b0, 1'b1, 10'h2A5, 10'h000, 4);
    run_frame("t5_next", 0, 1'b1, 1'b0, 1'b1, 10'h2A5, 10'h000, 22);

    // Reset mid MSB-first section
    e0 = err_cnt;
    ch0_data  = 10'h2A5;
    spi_if.cs = 1'b0;
    repeat (4) @(negedge clk_i);
    spi_clk(1'b1, d, oe);
    spi_clk(1'b1, d, oe);
    spi_clk(1'b0, d, oe);
    spi_clk(1'b1, d, oe);
    repeat (3) spi_clk(1'b0, d, oe);
    rst_ni = 1'b0;
    #1;
    check("t6_dout", 32'(spi_if.dout), 32'd0);
    check("t6_oe", 32'(spi_if.dout_oe), 32'd0);
    check("t6_conv_value", 32'(conv_value), 32'd0);
    check("t6_conv_cfg", 32'(conv_cfg), 32'd0);
    check("t6_conv_done", 32'(conv_done), 32'd0);
    spi_if.cs = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (6) @(negedge clk_i);
    check("t6_no_err", 32'(err_cnt - e0), 32'd0);
    run_frame("t6_next", 0, 1'b1, 1'b0, 1'b1, 10'h2A5, 10'h000, 22);

    for (int i = 0; i < 12; i++) begin
      run_frame($sformatf("rnd%0d", i), int'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 1'($urandom), DW'($urandom), DW'($urandom), 22);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
